watchdog_rst_seq: RTL

//  Downstream of the watchdog: consumes its active-low nwWatchdogRst and converts a timeout into a

---
 rtl/watchdog_pkg.sv | 33 +++
 rtl/watchdog_sync2.sv | 23 ++
 rtl/watchdog_rst_seq.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/watchdog_pkg.sv
// Shared definitions for the watchdog and its downstream reset sequencer:
// local-bus register addresses, the software reset key, sequencer FSM states
// and STATUS register bit positions.
package watchdog_pkg;

    // Watchdog's own registers; the sequencer's map stays clear of these.
    localparam logic [7:0] WDT_CTRL_ADDR      = 8'h01;
    localparam logic [7:0] WDT_LOAD_ADDR      = 8'h04;
    localparam logic [7:0] WDT_KICK_ADDR      = 8'h08;

    // Reset sequencer registers.
    localparam logic [7:0] RSTSEQ_STATUS_ADDR = 8'h10;
    localparam logic [7:0] RSTSEQ_CLEAR_ADDR  = 8'h14;
    localparam logic [7:0] RSTSEQ_SWRST_ADDR  = 8'h18;

    // Software reset key written to the low byte of the SWRST register.
    localparam logic [7:0] SW_RST_KEY         = 8'hA5;

    // STATUS register layout.
    localparam int STAT_WDT_BIT    = 0;
    localparam int STAT_SW_BIT     = 1;
    localparam int STAT_MISSED_BIT = 2;
    localparam int STAT_BUSY_BIT   = 3;
    localparam int STAT_COUNT_LSB  = 8;

    // Reset sequencer FSM states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        RELEASE = 2'd2
    } rstSeqState_t;

endpackage

// File: rtl/watchdog_sync2.sv
// Two-flop synchronizer for an active-low level. Resets to 1 so that a
// deasserted (high) input is assumed while the local bus is in reset.
module watchdog_sync2 (
    input  logic wLB_Clk,
    input  logic nwLB_Rst,
    input  logic syncIn,
    output logic syncOut
);

    logic syncMeta;

    // Shift the asynchronous input through two flops into the clock domain.
    always_ff @(posedge wLB_Clk or negedge nwLB_Rst) begin
        if (!nwLB_Rst) begin
            syncMeta <= 1'b1;
            syncOut  <= 1'b1;
        end else begin
            syncMeta <= syncIn;
            syncOut  <= syncMeta;
        end
    end

endmodule

// File: rtl/watchdog_rst_seq.sv
// Watchdog reset sequencer. Turns a watchdog timeout (falling edge of
// nwWatchdogRst) into a fixed-length system reset pulse followed by a delayed
// peripheral reset release, and records the cause and a saturating event count.
// Optional feature macro: WDT_SW_RST_EN enables the 0x18 software reset key
// register and the SW cause bit.
module watchdog_rst_seq
    import watchdog_pkg::*;
#(
    parameter int RST_PULSE_CYCLES  = 16,
    parameter int PERIPH_DLY_CYCLES = 8
) (
    input  logic        wLB_Clk,
    input  logic        nwLB_Rst,
    input  logic        nwWatchdogRst,
    input  logic        wLB_wr,
    input  logic        wLB_rd,
    input  logic [7:0]  wLB_add,
    input  logic [31:0] wLB_wr_data,
    output logic [31:0] bLB_rd_data,
    output logic        wLB_rd_valid,
    output logic        nwSysRst,
    output logic        nwPeriphRst
);

    localparam int CNT_MAX = (RST_PULSE_CYCLES > PERIPH_DLY_CYCLES) ?
                             RST_PULSE_CYCLES : PERIPH_DLY_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DLY_LOAD   = CNT_W'(PERIPH_DLY_CYCLES - 1);

    rstSeqState_t     seqState;
    logic [CNT_W-1:0] seqCnt;
    logic             wdtSync;
    logic             wdtPrev;
    logic             wdtEdge;
    logic             swTrig;
    logic             anyTrig;
    logic             clearHit;
    logic             causeWdt;
    logic             causeSw;
    logic             missedFlag;
    logic [7:0]       eventCount;
    logic [31:0]      statusWord;
    logic             unusedWrData;

    watchdog_sync2 uWdtSync (
        .wLB_Clk (wLB_Clk),
        .nwLB_Rst(nwLB_Rst),
        .syncIn  (nwWatchdogRst),
        .syncOut (wdtSync)
    );

    // Register the falling edge of the synchronized watchdog level so a held-low input fires once.
    always_ff @(posedge wLB_Clk or negedge nwLB_Rst) begin
        if (!nwLB_Rst) begin
            wdtPrev <= 1'b1;
            wdtEdge <= 1'b0;
        end else begin
            wdtPrev <= wdtSync;
            wdtEdge <= wdtPrev & ~wdtSync;
        end
    end

`ifdef WDT_SW_RST_EN
    assign swTrig = wLB_wr && (wLB_add == RSTSEQ_SWRST_ADDR) &&
                    (wLB_wr_data[7:0] == SW_RST_KEY);
`else
    assign swTrig = 1'b0;
`endif

    assign unusedWrData = ^wLB_wr_data;
    assign anyTrig      = wdtEdge | swTrig;
    assign clearHit     = wLB_wr && (wLB_add == RSTSEQ_CLEAR_ADDR);

    // Sequencer FSM: one shared down-counter times both the pulse and the peripheral delay.
    always_ff @(posedge wLB_Clk or negedge nwLB_Rst) begin
        if (!nwLB_Rst) begin
            seqState    <= ASSERT;
            seqCnt      <= PULSE_LOAD;
            nwSysRst    <= 1'b0;
            nwPeriphRst <= 1'b0;
        end else begin
            case (seqState)
                IDLE: begin
                    if (anyTrig) begin
                        seqState    <= ASSERT;
                        seqCnt      <= PULSE_LOAD;
                        nwSysRst    <= 1'b0;
                        nwPeriphRst <= 1'b0;
                    end
                end
                ASSERT: begin
                    if (seqCnt == '0) begin
                        seqState <= RELEASE;
                        seqCnt   <= DLY_LOAD;
                        nwSysRst <= 1'b1;
                    end else begin
                        seqCnt <= seqCnt - 1'b1;
                    end
                end
                RELEASE: begin
                    if (seqCnt == '0) begin
                        seqState    <= IDLE;
                        nwPeriphRst <= 1'b1;
                    end else begin
                        seqCnt <= seqCnt - 1'b1;
                    end
                end
                default: begin
                    seqState    <= ASSERT;
                    seqCnt      <= PULSE_LOAD;
                    nwSysRst    <= 1'b0;
                    nwPeriphRst <= 1'b0;
                end
            endcase
        end
    end

    // Cause, missed and count registers; a same-cycle clear is applied before the trigger.
    always_ff @(posedge wLB_Clk or negedge nwLB_Rst) begin
        if (!nwLB_Rst) begin
            causeWdt   <= 1'b0;
            causeSw    <= 1'b0;
            missedFlag <= 1'b0;
            eventCount <= 8'h00;
        end else begin
            if (anyTrig && (seqState == IDLE)) begin
                causeWdt <= wdtEdge;
                causeSw  <= swTrig;
            end else if (clearHit) begin
                causeWdt <= 1'b0;
                causeSw  <= 1'b0;
            end

            if (anyTrig && (seqState != IDLE)) begin
                missedFlag <= 1'b1;
            end else if (clearHit) begin
                missedFlag <= 1'b0;
            end

            if (anyTrig) begin
                if (clearHit) begin
                    eventCount <= 8'h01;
                end else if (eventCount != 8'hFF) begin
                    eventCount <= eventCount + 8'h01;
                end
            end else if (clearHit) begin
                eventCount <= 8'h00;
            end
        end
    end

    // Assemble the STATUS word from the live state and the recorded event bits.
    always_comb begin
        statusWord                            = '0;
        statusWord[STAT_WDT_BIT]              = causeWdt;
        statusWord[STAT_SW_BIT]               = causeSw;
        statusWord[STAT_MISSED_BIT]           = missedFlag;
        statusWord[STAT_BUSY_BIT]             = (seqState != IDLE);
        statusWord[STAT_COUNT_LSB +: 8]       = eventCount;
    end

    // Registered read port: data is driven only alongside the one-cycle valid pulse.
    always_ff @(posedge wLB_Clk or negedge nwLB_Rst) begin
        if (!nwLB_Rst) begin
            wLB_rd_valid <= 1'b0;
            bLB_rd_data  <= 32'h0;
        end else if (wLB_rd && (wLB_add == RSTSEQ_STATUS_ADDR)) begin
            wLB_rd_valid <= 1'b1;
            bLB_rd_data  <= statusWord;
        end else begin
            wLB_rd_valid <= 1'b0;
            bLB_rd_data  <= 32'h0;
        end
    end

endmodule
